// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - data bus request/acknowledge interface for the memory-access stage
//
// Purpose: bundles the data bus between the MEM stage (master) and memory (slave).
// Signals:
//   dbus_req   master->slave  bus request, held until dbus_ack
//   dbus_we    master->slave  1 = write
//   dbus_sel   master->slave  byte enables, bit n = byte [8n+7:8n]
//   dbus_addr  master->slave  word-aligned address
//   dbus_wdata master->slave  lane-replicated store data
//   dbus_rdata slave->master  read data, valid with dbus_ack
//   dbus_ack   slave->master  one-cycle completion strobe

interface mem_access_if;
    logic        dbus_req;
    logic        dbus_we;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [31:0] dbus_rdata;
    logic        dbus_ack;

    modport master (
        output dbus_req, dbus_we, dbus_sel, dbus_addr, dbus_wdata,
        input  dbus_rdata, dbus_ack
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_sel, dbus_addr, dbus_wdata,
        output dbus_rdata, dbus_ack
    );
endinterface

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MIPS memory-access stage: bus transaction, load formatting, LL/SC link
//
// Purpose: decodes the EX/MEM load/store op, runs one request/acknowledge bus
// transaction per aligned memop, formats load data, tracks the LL/SC link bit
// and produces the writeback fields captured by MEM/WB.
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   ex_memop        0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW, 9 LL, 10 SC
//   ex_addr         effective byte address
//   ex_sdata        store data
//   ex_wd/ex_wreg/ex_wdata/ex_whilo/ex_hi/ex_lo   writeback fields from EX/MEM
//   ll_clear        clears the link bit (exception/ERET)
//   dbus            data bus master port (registered request fields)
//   mem_wd/mem_wreg/mem_wdata/mem_whilo/mem_hi/mem_lo   writeback fields to MEM/WB
//   mem_adel/mem_ades   load/store address error
//   stallreq        holds the pipeline while a transaction is outstanding

module mem_access (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        ex_memop,
    input  logic [31:0]       ex_addr,
    input  logic [31:0]       ex_sdata,
    input  logic [4:0]        ex_wd,
    input  logic              ex_wreg,
    input  logic [31:0]       ex_wdata,
    input  logic              ex_whilo,
    input  logic [31:0]       ex_hi,
    input  logic [31:0]       ex_lo,
    input  logic              ll_clear,
    mem_access_if.master      dbus,
    output logic [4:0]        mem_wd,
    output logic              mem_wreg,
    output logic [31:0]       mem_wdata,
    output logic              mem_whilo,
    output logic [31:0]       mem_hi,
    output logic [31:0]       mem_lo,
    output logic              mem_adel,
    output logic              mem_ades,
    output logic              stallreq
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;
    localparam logic [3:0] OP_LL  = 4'd9;
    localparam logic [3:0] OP_SC  = 4'd10;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state, state_n;
    logic        link_q;
    logic [31:0] rdata_q;

    logic        is_load, is_store, misaligned;
    logic [3:0]  sel_n;
    logic [31:0] wdata_n;
    logic        is_sc, sc_fail, start;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_fmt;

    // Op decode, alignment and store lane placement.
    always_comb begin
        is_load    = 1'b0;
        is_store   = 1'b0;
        misaligned = 1'b0;
        sel_n      = 4'b1111;
        wdata_n    = ex_sdata;
        case (ex_memop)
            OP_LB, OP_LBU: is_load = 1'b1;
            OP_LH, OP_LHU: begin
                is_load    = 1'b1;
                misaligned = ex_addr[0];
            end
            OP_LW, OP_LL: begin
                is_load    = 1'b1;
                misaligned = |ex_addr[1:0];
            end
            OP_SB: begin
                is_store = 1'b1;
                sel_n    = 4'b0001 << ex_addr[1:0];
                wdata_n  = {4{ex_sdata[7:0]}};
            end
            OP_SH: begin
                is_store   = 1'b1;
                misaligned = ex_addr[0];
                sel_n      = 4'b0011 << {ex_addr[1], 1'b0};
                wdata_n    = {2{ex_sdata[15:0]}};
            end
            OP_SW, OP_SC: begin
                is_store   = 1'b1;
                misaligned = |ex_addr[1:0];
            end
            default: ;
        endcase
    end

    assign is_sc   = (ex_memop == OP_SC);
    // A misaligned SC reports an address error rather than a link failure.
    assign sc_fail = is_sc && !link_q && !misaligned;
    assign start   = (state == IDLE) && (is_load || is_store) && !misaligned && !sc_fail;

    // Load formatting works off the captured word; ex_addr is held stable by the stall.
    assign lane_b = rdata_q[{ex_addr[1:0], 3'b000} +: 8];
    assign lane_h = rdata_q[{ex_addr[1], 4'b0000} +: 16];

    always_comb begin
        case (ex_memop)
            OP_LB:   load_fmt = {{24{lane_b[7]}}, lane_b};
            OP_LBU:  load_fmt = {24'd0, lane_b};
            OP_LH:   load_fmt = {{16{lane_h[15]}}, lane_h};
            OP_LHU:  load_fmt = {16'd0, lane_h};
            default: load_fmt = rdata_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        mem_wd    = ex_wd;
        mem_wreg  = ex_wreg;
        mem_wdata = ex_wdata;
        mem_whilo = ex_whilo;
        mem_hi    = ex_hi;
        mem_lo    = ex_lo;
        mem_adel  = 1'b0;
        mem_ades  = 1'b0;
        stallreq  = 1'b0;
        case (state)
            IDLE: begin
                if (misaligned) begin
                    mem_adel = is_load;
                    mem_ades = is_store;
                    mem_wreg = 1'b0;
                end else if (sc_fail) begin
                    mem_wdata = 32'd0;
                end else if (start) begin
                    stallreq  = 1'b1;
                    mem_wreg  = 1'b0;
                    mem_whilo = 1'b0;
                    state_n   = REQ;
                end
            end
            REQ: begin
                stallreq  = 1'b1;
                mem_wreg  = 1'b0;
                mem_whilo = 1'b0;
                if (dbus.dbus_ack) state_n = DONE;
            end
            DONE: begin
                if (is_load)    mem_wdata = load_fmt;
                else if (is_sc) mem_wdata = 32'd1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (rst) begin
            mem_wd    = 5'd0;
            mem_wreg  = 1'b0;
            mem_wdata = 32'd0;
            mem_whilo = 1'b0;
            mem_hi    = 32'd0;
            mem_lo    = 32'd0;
            mem_adel  = 1'b0;
            mem_ades  = 1'b0;
            stallreq  = 1'b0;
        end
    end

    // Bus request fields, captured read data and the link bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            dbus.dbus_req   <= 1'b0;
            dbus.dbus_we    <= 1'b0;
            dbus.dbus_sel   <= 4'd0;
            dbus.dbus_addr  <= 32'd0;
            dbus.dbus_wdata <= 32'd0;
            rdata_q         <= 32'd0;
            link_q          <= 1'b0;
        end else begin
            if (start) begin
                dbus.dbus_req   <= 1'b1;
                dbus.dbus_we    <= is_store;
                dbus.dbus_sel   <= sel_n;
                dbus.dbus_addr  <= {ex_addr[31:2], 2'b00};
                dbus.dbus_wdata <= wdata_n;
            end
            if (state == REQ && dbus.dbus_ack) begin
                dbus.dbus_req <= 1'b0;
                rdata_q       <= dbus.dbus_rdata;
            end
            // Only a successful SC ever reaches DONE, so clearing there is unconditional.
            if (ll_clear)
                link_q <= 1'b0;
            else if (state == DONE && ex_memop == OP_LL)
                link_q <= 1'b1;
            else if (state == DONE && is_sc)
                link_q <= 1'b0;
        end
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the 5-stage MIPS pipeline, between the EX/MEM pipeline register and the MEM/WB register.
- Decodes the load/store operation from EX/MEM.
- Runs a request/acknowledge transaction on the data bus and formats load data (lane select, sign/zero extend).
- Tracks the LL/SC link bit and produces the mem_* writeback fields that MEM/WB captures.
- Raises stallreq while a bus transaction is outstanding.

## Interface
Parameters: none.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ex_memop  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW, 9 LL, 10 SC; 11-15 treated as none
- ex_addr  in  32  effective byte address
- ex_sdata  in  32  store data (rt)
- ex_wd  in  5  destination register
- ex_wreg  in  1  register write enable
- ex_wdata  in  32  ALU result
- ex_whilo  in  1  HI/LO write enable
- ex_hi, ex_lo  in  32 each  HI/LO values
- ll_clear  in  1  clears link bit (exception/ERET)
- dbus_req  out  1  bus request, registered
- dbus_we  out  1  1 = write, registered
- dbus_sel  out  4  byte enables, bit n = byte [8n+7:8n] (little-endian), registered
- dbus_addr  out  32  word address {ex_addr[31:2],2'b00}, registered
- dbus_wdata  out  32  lane-replicated store data, registered
- dbus_rdata  in  32  read data, valid when dbus_ack=1
- dbus_ack  in  1  transaction complete, one cycle
- mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo  out  5/1/32/1/32/32  to MEM/WB
- mem_adel, mem_ades  out  1 each  load/store address error
- stallreq  out  1  stall request to pipeline control (holds PC..EX/MEM)

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE, memop none: mem_* pass through from ex_* combinationally; stallreq=0.
- Alignment and exceptions:
  - Misaligned if: LH/LHU/SH with addr[0]=1; LW/LL/SW/SC with addr[1:0]!=0.
  - Misaligned load: mem_adel=1. Misaligned store: mem_ades=1.
  - Misaligned: mem_wreg=0, no bus access, no stall, remain in IDLE.
- IDLE, aligned memop (except SC with link bit 0): stallreq=1 and mem_wreg=mem_whilo=0. At the clock edge, load the dbus_* registers, set dbus_req=1, go to REQ.
- REQ: dbus_req held with stable fields. stallreq=1, mem_wreg=mem_whilo=0. On dbus_ack: capture dbus_rdata into rdata_q, drop dbus_req, go to DONE.
- DONE: stallreq=0, mem_* valid.
  - Loads: mem_wdata = formatted rdata_q.
  - SC: mem_wdata = 1.
  - Other stores: mem_wdata = ex_wdata.
  - Next edge returns to IDLE. MEM/WB captures on the same edge.
- Load formatting:
  - LB/LBU: byte at lane addr[1:0], sign/zero extended.
  - LH/LHU: half at lane addr[1], sign/zero extended.
  - LW/LL: full word.
- Store lanes:
  - SB: sel = 0001<<addr[1:0], wdata = {4{sdata[7:0]}}.
  - SH: sel = 0011<<(2*addr[1]), wdata = {2{sdata[15:0]}}.
  - SW/SC: sel = 1111, wdata = sdata.
  - Loads: sel = 1111, we = 0.
- Link bit:
  - Set at the DONE edge of LL.
  - Cleared at the DONE edge of a successful SC, on ll_clear, or on reset.
  - ll_clear has priority over a simultaneous set.
- SC with link bit 0: no bus access, no stall, mem_wdata=0, mem_wreg=ex_wreg, completes in one cycle.

## Timing
- Reset (rst high at edge):
  - state=IDLE, link bit=0.
  - dbus_req=0, dbus_we=0, dbus_sel=0, dbus_addr=0, dbus_wdata=0.
  - While rst is high, all mem_* outputs, mem_adel, mem_ades and stallreq are driven 0.
- Reset during REQ abandons the transaction: dbus_req=0 from the next cycle, and a late dbus_ack is ignored in IDLE.
- Latency: a memop with ack in the first REQ cycle occupies 3 cycles (IDLE, REQ, DONE), so stallreq is high for 2 cycles. Each extra wait cycle adds 1.
- ex_* are stable while stallreq=1 (the pipeline holds EX/MEM). The block relies on this.
- dbus_ack outside REQ is ignored.
- Back-to-back memops: the second is sampled in IDLE on the cycle after DONE.

## Test plan
- LB: addr 0x1003, rdata 0x80FF_1234 with ack after 2 wait cycles. Required: dbus_sel=1111, dbus_we=0, stallreq high 4 cycles; DONE mem_wdata=0xFFFF_FF80, mem_wreg=1.
- SH: addr 0x2002, sdata 0x0000_ABCD, immediate ack. Required: dbus_sel=1100, dbus_wdata=0xABCD_ABCD, dbus_we=1, stallreq high 2 cycles.
- LW at addr 0x3001. Required: mem_adel=1, mem_wreg=0, dbus_req stays 0, stallreq=0.
- LL 0x4000 then SC 0x4000: SC does a bus write, mem_wdata=1. A second SC: no bus request, mem_wdata=0, stallreq=0.
- LL, then pulse ll_clear, then SC. Required: SC fails with mem_wdata=0 and no bus access.
- rst asserted during REQ. Required: dbus_req=0 next cycle, outputs 0, a following ack ignored, link bit 0.
